bram_req_ctrl: RTL

- Initiator-side port controller that drives one port of the team's synchronous dual-port BRAM: registered read data, one-cycle read latency, read-before-write on the same address.
- Takes a valid/ready request stream of reads and writes and issues each request to the BRAM port in order.
- Returns read data on a valid/ready response stream, buffered so that response backpressure never loses BRAM output.
- One instance per BRAM port; two instances cover a full dual-port memory.

---
 rtl/bram_ctrl_pkg.sv | 18 +
 rtl/bram_req_ctrl_resp_fifo.sv | 87 ++++++++
 rtl/bram_req_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared types and helpers for the BRAM port request controller.
package bram_ctrl_pkg;

    localparam int BRAM_RD_LATENCY = 1;
    localparam int REQ_ADDR_W      = 10;
    localparam int REQ_DATA_W      = 8;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } req_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_req_ctrl_resp_fifo.sv
// Response FIFO: registered head output, occupancy count, any depth >= 2.
module resp_fifo
    import bram_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CW    = cnt_width(DEPTH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CW-1:0]    count
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign valid  = (count_q != '0);
    assign do_pop = pop && valid;
    assign dout   = dout_q;
    assign count  = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (push)
            wr_ptr_d = inc(wr_ptr_q);
        if (do_pop)
            rd_ptr_d = inc(rd_ptr_q);
        case ({push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Head register follows the entry that becomes head after this edge.
        if (do_pop) begin
            if (count_q > CW'(1))
                dout_d = mem_q[inc(rd_ptr_q)];
            else if (push)
                dout_d = din;
        end else if (!valid && push) begin
            dout_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= din;
    end

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && count_q == CW'(DEPTH))
    );

endmodule

// File: rtl/bram_req_ctrl.sv
// Initiator-side controller for one port of a 1-cycle-latency BRAM,
// with credit-based request flow and a buffered read response stream.
module bram_req_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter  int ADDR_WIDTH = 10,
    parameter  int DATA_WIDTH = 8,
    parameter  int RSP_DEPTH  = 4,
    localparam int CW         = cnt_width(RSP_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [CW-1:0]         rd_inflight
);

    logic          live_q, live_d;
    logic          rd_pend_q, rd_pend_d;
    logic          accept;
    logic [CW-1:0] buf_count;

    // Credit counts both buffered data and the read still inside the BRAM.
    assign rd_inflight = buf_count + CW'(rd_pend_q);
    assign req_ready   = live_q && (rd_inflight < CW'(RSP_DEPTH));
    assign accept      = req_valid && req_ready;

    assign bram_addr = req_addr;
    assign bram_din  = req_wdata;
    assign bram_we   = accept && req_we;

    always_comb begin
        live_d    = 1'b1;
        rd_pend_d = accept && !req_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            live_q    <= live_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    resp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend_q),
        .din   (bram_dout),
        .pop   (rsp_ready),
        .dout  (rsp_data),
        .valid (rsp_valid),
        .count (buf_count)
    );

endmodule
